// File: rtl/sop_pkg.sv
// Shared constants and helpers for the sum-of-products datapath blocks.
package sop_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int OCC_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sop_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data word, loaded when the slot may advance.
module sop_pipe_stage
    import sop_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Data only moves with a real beat, so an empty load leaves the old word in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            v <= src_valid;
            if (src_valid) begin
                d <= src_data;
            end
        end
    end

endmodule

// File: rtl/sop_pipe_chain.sv
// Stallable DEPTH-stage register chain with valid/ready handshake, bubble collapse,
// synchronous flush and occupancy count.
module sop_pipe_chain
    import sop_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [OCC_W(DEPTH)-1:0]   occupancy
);

    localparam int OW = OCC_W(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [OW-1:0]    occ;

    // A stage may advance when it is empty or everything ahead of it will move.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~v[i] | rdy[i + 1];
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OW'(v[i]);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = v[i - 1];
            assign src_data  = d[i - 1];
        end

        sop_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush),
            .load     (rdy[i]),
            .src_valid(src_valid),
            .src_data (src_data),
            .v        (v[i]),
            .d        (d[i])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH - 1];
    assign out_data  = d[DEPTH - 1];
    assign occupancy = occ;

endmodule

// File: tb/tb_sop_pipe_chain.sv
// Randomized and directed bench for sop_pipe_chain against a queue-based reference model.
module tb_sop_pipe_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    int vectors = 0;
    int miscompares = 0;
    int cycleCount = 0;

    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] outLog[$];
    int               outCyc[$];
    int               inCyc[$];
    bit               lastInTx;

    always #5 clk = ~clk;

    sop_pipe_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance the queue model at posedge.
    task automatic applyStimulus(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, input bit fl);
        bit expReady;
        bit outTx;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        expReady = !fl && ((model.size() < DEPTH) || ordy);
        if (!rst) checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        checkOutput("occupancy", {30'd0, occupancy}, model.size());
        if (model.size() == 0)
            checkOutput("out_valid_empty", {31'd0, out_valid}, 32'd0);
        else if (out_valid)
            checkOutput("out_data", {24'd0, out_data}, {24'd0, model[0]});
        outTx    = out_valid && ordy && !rst;
        lastInTx = iv && expReady && !rst;
        if (outTx) begin
            outLog.push_back(out_data);
            outCyc.push_back(cycleCount);
        end
        if (lastInTx) inCyc.push_back(cycleCount);
        @(posedge clk);
        cycleCount++;
        if (rst || fl) begin
            model.delete();
        end else begin
            if (outTx && model.size() > 0) void'(model.pop_front());
            if (lastInTx) model.push_back(id);
        end
        #1;
    endtask

    task automatic clearLogs();
        outLog.delete();
        outCyc.delete();
        inCyc.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int idx;
        logic [WIDTH-1:0] beats[5];
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a beat offered.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
            checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
            checkOutput("rst_occupancy", {30'd0, occupancy}, 32'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #1;
        checkOutput("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming 01..0A with out_ready high.
        clearLogs();
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
        drain(6);
        checkOutput("stream_count", outLog.size(), 32'd10);
        if (outLog.size() == 10 && inCyc.size() > 0) begin
            checkOutput("stream_latency", outCyc[0] - inCyc[0], DEPTH);
            for (int i = 0; i < 10; i++) begin
                checkOutput("stream_data", {24'd0, outLog[i]}, i + 1);
                checkOutput("stream_gapless", outCyc[i] - outCyc[0], i);
            end
        end

        // Full stall: five beats offered, three fit.
        clearLogs();
        for (int i = 0; i < 5; i++) beats[i] = 8'h10 + 8'(i);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, beats[idx], 1'b0, 1'b0);
            if (lastInTx) idx++;
        end
        checkOutput("stall_accepted", idx, 32'd3);
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("stall_occupancy", {30'd0, occupancy}, 32'd3);
        for (int c = 0; c < 20 && idx < 5; c++) begin
            applyStimulus(1'b1, beats[idx], 1'b1, 1'b0);
            if (lastInTx) idx++;
        end
        drain(6);
        checkOutput("stall_count", outLog.size(), 32'd5);
        if (outLog.size() == 5)
            for (int i = 0; i < 5; i++) checkOutput("stall_order", {24'd0, outLog[i]}, 32'h10 + i);

        // Bubble collapse with output stalled.
        clearLogs();
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h23; out_ready = 1'b0;
        #1;
        checkOutput("bubble_occupancy", {30'd0, occupancy}, 32'd3);
        checkOutput("bubble_in_ready", {31'd0, in_ready}, 32'd0);
        drain(6);
        checkOutput("bubble_count", outLog.size(), 32'd3);
        if (outLog.size() == 3)
            for (int i = 0; i < 3; i++) checkOutput("bubble_order", {24'd0, outLog[i]}, 32'h20 + i);

        // Full chain passes a beat through while delivering one.
        clearLogs();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h2A + 8'(i), 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h30; out_ready = 1'b1;
        #1;
        checkOutput("pass_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
        checkOutput("pass_occupancy", {30'd0, occupancy}, 32'd3);
        drain(6);
        checkOutput("pass_count", outLog.size(), 32'd4);
        if (outLog.size() == 4) checkOutput("pass_last", {24'd0, outLog[3]}, 32'h30);

        // Flush with two beats held and a beat offered.
        clearLogs();
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0; flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        checkOutput("flush_occupancy", {30'd0, occupancy}, 32'd0);
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        drain(6);
        checkOutput("flush_count", outLog.size(), 32'd0);

        // Random traffic with occasional flush and one reset pulse.
        for (int c = 0; c < 400; c++) begin
            rst = (c == 200);
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end
        rst = 1'b0;
        drain(DEPTH + 4);
        checkOutput("final_drain", model.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
